waveform_packetizer: RTL and testbench
======================================

# waveform_packetizer

Consumer side of the trigger-window path: accepts the windowed ADC waveform, window-active flag and pulse height produced by the trigger/windowing stage, buffers one window, and serializes it as a byte frame for the UART transmitter over a valid/ready byte interface. It sits between the windowing stage and the UART TX core. Windows arriving while a frame is still being sent are dropped and counted.

## Interface
- WINDOW_LEN, 42: maximum samples captured per window, range 1–255.
- SAMPLE_W, 14: ADC sample width, range 9–16.

- clk  in  1  system clock, ADC sample rate.
- rst  in  1  synchronous, active-high reset.
- win_active  in  1  window flag from the windowing stage; high for one contiguous run per window.
- win_sample  in  SAMPLE_W  waveform sample; valid while win_active=1.
- pulse_height  in  SAMPLE_W  pulse height; stable when win_active falls.
- tx_data  out  8  frame byte to the UART TX.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART TX accepts a byte.
- busy  out  1  high from capture start until the last frame byte is accepted.
- drop_count  out  8  count of dropped windows, saturating.

## Operation
- Reset values: tx_data=0, tx_valid=0, busy=0, drop_count=0. Sequence counter=0. State=IDLE.
- States: IDLE → CAPTURE → SEND → IDLE.
- IDLE: a rising edge of win_active (high now, low last cycle) → CAPTURE. The sample in that cycle is written at index 0. If win_active is already high on entry to IDLE, wait for it to go low and then high again. Partial windows are never captured.
- CAPTURE: one sample is written per cycle while win_active=1, at index 0..WINDOW_LEN-1. Samples beyond WINDOW_LEN are ignored. LEN = number stored. When win_active=0, latch pulse_height and LEN, then → SEND.
- Frame format: 0xA5, SEQ, LEN, PH_HI, PH_LO, then per sample S_HI, S_LO, then an optional CSUM.
  - Each value is zero-extended to 16 bits and sent big-endian.
  - SEQ increments by 1 after the last byte of each frame is accepted and wraps 255→0.
- Handshake: a byte transfers when tx_valid && tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data stays stable and tx_valid stays high.
  - With tx_ready held high, one byte transfers per cycle with no gaps within a frame. The buffer read is prefetched to make this possible.
- Drops: each rising edge of win_active seen in SEND adds 1 to drop_count, which saturates at 255. The capture buffer is not touched.
- Rising edge of win_active in the same cycle the last byte is accepted: counts as a drop, and the block returns to IDLE.
- rst mid-frame: the frame is aborted and tx_valid=0 from the next cycle. All state returns to reset values.

## Timing
- Capture: write latency 0. The sample present at posedge k while win_active=1 is stored at posedge k.
- First win_active=0 cycle (posedge F): latch pulse_height and enter SEND.
- tx_valid=1 with 0xA5 in the cycle after F.
- Frame length: 5+2·LEN bytes, or 6+2·LEN with checksum. Minimum send duration equals that many cycles.
- busy rises in the cycle after the rising edge is sampled. busy falls in the cycle after the last byte is accepted.

## Configuration
- PKT_CHECKSUM_EN defined: a CSUM byte is appended. CSUM is the 8-bit modulo-256 sum of all frame bytes from SEQ through the last S_LO, excluding 0xA5.
- PKT_CHECKSUM_EN undefined: the frame ends after the last S_LO and no checksum logic is built.

## Structure
- Package pkt_pkg holds:
  - SYNC_BYTE = 8'hA5;
  - the state enum (IDLE, CAPTURE, SEND);
  - the byte-select enum (HDR, SEQ, LEN, PH_HI, PH_LO, S_HI, S_LO, CSUM);
  - header byte count = 5.
- One sub-module: pkt_sample_ram, a simple dual-port WINDOW_LEN×SAMPLE_W buffer with synchronous write and one-cycle registered read.

## Test plan
- Window of 10 samples 100..109, pulse_height=500, tx_ready=1:
  - bytes A5 00 0A 01 F4 00 64 … 00 6D in 25 consecutive cycles;
  - with PKT_CHECKSUM_EN, the final byte is the modulo-256 sum of all non-sync bytes.
- win_active high for 60 cycles → LEN=0x2A (42); only the first 42 samples are sent.
- tx_ready toggled 1/0 every cycle → tx_data stable while stalled; the byte sequence is identical to the first test.
- Two windows inside one frame → drop_count=2 and the sent frame is unchanged. A third window after the frame ends → SEQ=01.
- 256 frames → SEQ wraps from FF to 00. 300 dropped windows → drop_count holds at 255.
- rst asserted in the middle of the PH_HI byte → tx_valid=0 next cycle. The next window produces a frame with SEQ=00.

Source files
------------

// File: rtl/pkt_pkg.sv
// pkt_pkg: shared types and constants for the waveform packetizer.
//   SYNC_BYTE  - first byte of every frame
//   HDR_BYTES  - bytes ahead of the sample payload (sync, seq, len, ph_hi, ph_lo)
//   state_e    - controller states
//   byte_sel_e - which frame field is currently presented on tx_data
//   hi8/lo8    - big-endian byte split of a 16-bit value
//   sat_inc8   - saturating 8-bit increment
package pkt_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         HDR_BYTES = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SEND    = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    SEQ   = 3'd1,
    LEN   = 3'd2,
    PH_HI = 3'd3,
    PH_LO = 3'd4,
    S_HI  = 3'd5,
    S_LO  = 3'd6,
    CSUM  = 3'd7
  } byte_sel_e;

  function automatic logic [7:0] hi8(input logic [15:0] v);
    return v[15:8];
  endfunction

  function automatic logic [7:0] lo8(input logic [15:0] v);
    return v[7:0];
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/pkt_sample_ram.sv
// pkt_sample_ram: DEPTH x WIDTH simple dual-port sample buffer.
//   clk, rst       - clock, synchronous active-high reset (read register only)
//   we/waddr/wdata - synchronous write port
//   re/raddr       - read request; rdata is registered and updates one edge
//                    after a request, holding its value otherwise
module pkt_sample_ram
  import pkt_pkg::*;
#(
  parameter int DEPTH  = 42,
  parameter int WIDTH  = 14,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_d;
  logic [WIDTH-1:0] rdata_q;

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data holds between requests so the consumer can use it across stalls.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[raddr];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Read data register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {WIDTH{1'b0}};
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/waveform_packetizer.sv
// waveform_packetizer: captures one trigger window of ADC samples and sends it
// as a byte frame over a valid/ready interface:
//   A5, SEQ, LEN, PH_HI, PH_LO, {S_HI, S_LO} x LEN [, CSUM]
// Windows starting while a frame is being sent are dropped and counted.
// Optional feature macro: PKT_CHECKSUM_EN appends a modulo-256 sum of all
// bytes after the sync byte.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   win_active, win_sample    - window flag and sample stream
//   pulse_height              - latched on the first cycle after the window
//   tx_data, tx_valid, tx_ready - byte stream to the UART transmitter
//   busy                      - capture or send in progress
//   drop_count                - saturating count of dropped windows
module waveform_packetizer
  import pkt_pkg::*;
#(
  parameter int WINDOW_LEN = 42,
  parameter int SAMPLE_W   = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                win_active,
  input  logic [SAMPLE_W-1:0] win_sample,
  input  logic [SAMPLE_W-1:0] pulse_height,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                busy,
  output logic [7:0]          drop_count
);

  localparam int         ADDR_W    = (WINDOW_LEN > 1) ? $clog2(WINDOW_LEN) : 1;
  localparam logic [7:0] WIN_LEN_B = 8'(WINDOW_LEN);

  state_e              state_q, state_d;
  byte_sel_e           sel_q, sel_d;
  logic                win_prev_q, win_prev_d;
  logic [7:0]          wr_idx_q, wr_idx_d;
  logic [7:0]          len_q, len_d;
  logic [SAMPLE_W-1:0] ph_q, ph_d;
  logic [7:0]          rd_idx_q, rd_idx_d;
  logic [7:0]          seq_q, seq_d;
  logic [7:0]          drop_q, drop_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                busy_q, busy_d;
`ifdef PKT_CHECKSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic                rise_s;
  logic                accept_s;
  logic [7:0]          rd_next_s;
  logic                samples_done_s;
  logic                last_byte_s;
  logic                frame_done_s;

  logic                ram_we_s;
  logic [ADDR_W-1:0]   ram_waddr_s;
  logic [SAMPLE_W-1:0] ram_wdata_s;
  logic                ram_re_s;
  logic [ADDR_W-1:0]   ram_raddr_s;
  logic [SAMPLE_W-1:0] ram_rdata_s;

  pkt_sample_ram #(
    .DEPTH  (WINDOW_LEN),
    .WIDTH  (SAMPLE_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we_s),
    .waddr (ram_waddr_s),
    .wdata (ram_wdata_s),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Event decode shared by the next-state and datapath logic.
  always_comb begin
    rise_s         = win_active & ~win_prev_q;
    accept_s       = tx_valid_q & tx_ready;
    rd_next_s      = rd_idx_q + 8'd1;
    samples_done_s = (rd_next_s >= len_q);
`ifdef PKT_CHECKSUM_EN
    last_byte_s    = (sel_q == CSUM);
`else
    last_byte_s    = (sel_q == S_LO) && samples_done_s;
`endif
    frame_done_s   = (state_q == SEND) && accept_s && last_byte_s;
  end

  // State register and all datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sel_q      <= HDR;
      // Treat the flag as already high so a window in progress at reset is skipped.
      win_prev_q <= 1'b1;
      wr_idx_q   <= 8'd0;
      len_q      <= 8'd0;
      ph_q       <= {SAMPLE_W{1'b0}};
      rd_idx_q   <= 8'd0;
      seq_q      <= 8'd0;
      drop_q     <= 8'd0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      win_prev_q <= win_prev_d;
      wr_idx_q   <= wr_idx_d;
      len_q      <= len_d;
      ph_q       <= ph_d;
      rd_idx_q   <= rd_idx_d;
      seq_q      <= seq_d;
      drop_q     <= drop_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
`ifdef PKT_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  // Controller next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rise_s) begin
          state_d = CAPTURE;
        end else begin
          state_d = IDLE;
        end
      end
      CAPTURE: begin
        if (!win_active) begin
          state_d = SEND;
        end else begin
          state_d = CAPTURE;
        end
      end
      SEND: begin
        if (frame_done_s) begin
          state_d = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture writes, frame byte sequencing, drop counting and checksum.
  always_comb begin
    win_prev_d  = win_active;
    sel_d       = sel_q;
    wr_idx_d    = wr_idx_q;
    len_d       = len_q;
    ph_d        = ph_q;
    rd_idx_d    = rd_idx_q;
    seq_d       = seq_q;
    drop_d      = drop_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = tx_valid_q;
    busy_d      = busy_q;
    ram_we_s    = 1'b0;
    ram_waddr_s = {ADDR_W{1'b0}};
    ram_wdata_s = win_sample;
    ram_re_s    = 1'b0;
    ram_raddr_s = {ADDR_W{1'b0}};
`ifdef PKT_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      IDLE: begin
        if (rise_s) begin
          // The sample in the rising-edge cycle is index 0.
          ram_we_s = 1'b1;
          wr_idx_d = 8'd1;
          busy_d   = 1'b1;
        end else begin
          wr_idx_d = 8'd0;
        end
      end

      CAPTURE: begin
        if (win_active) begin
          if (wr_idx_q < WIN_LEN_B) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = wr_idx_q[ADDR_W-1:0];
            wr_idx_d    = wr_idx_q + 8'd1;
          end else begin
            wr_idx_d    = wr_idx_q;
          end
        end else begin
          len_d      = wr_idx_q;
          ph_d       = pulse_height;
          tx_valid_d = 1'b1;
          tx_data_d  = SYNC_BYTE;
          sel_d      = HDR;
          rd_idx_d   = 8'd0;
          // Prefetch sample 0 so it is ready well before the payload starts.
          ram_re_s   = 1'b1;
          ram_raddr_s = {ADDR_W{1'b0}};
        end
      end

      SEND: begin
        if (rise_s) begin
          drop_d = sat_inc8(drop_q);
        end else begin
          drop_d = drop_q;
        end

        if (frame_done_s) begin
          tx_valid_d = 1'b0;
          tx_data_d  = 8'd0;
          busy_d     = 1'b0;
          seq_d      = seq_q + 8'd1;
          sel_d      = HDR;
        end else if (accept_s) begin
          case (sel_q)
            HDR: begin
              tx_data_d = seq_q;
              sel_d     = SEQ;
            end
            SEQ: begin
              tx_data_d = len_q;
              sel_d     = LEN;
            end
            LEN: begin
              tx_data_d = hi8(16'(ph_q));
              sel_d     = PH_HI;
            end
            PH_HI: begin
              tx_data_d = lo8(16'(ph_q));
              sel_d     = PH_LO;
            end
            PH_LO: begin
              tx_data_d = hi8(16'(ram_rdata_s));
              sel_d     = S_HI;
            end
            S_HI: begin
              tx_data_d = lo8(16'(ram_rdata_s));
              sel_d     = S_LO;
              // Low byte is taken from the current read data on this same
              // edge, so the next sample can be fetched now.
              if (!samples_done_s) begin
                ram_re_s    = 1'b1;
                ram_raddr_s = rd_next_s[ADDR_W-1:0];
              end else begin
                ram_re_s    = 1'b0;
              end
            end
            S_LO: begin
              if (!samples_done_s) begin
                rd_idx_d  = rd_next_s;
                tx_data_d = hi8(16'(ram_rdata_s));
                sel_d     = S_HI;
              end else begin
`ifdef PKT_CHECKSUM_EN
                tx_data_d = csum_q;
                sel_d     = CSUM;
`else
                tx_data_d = tx_data_q;
                sel_d     = sel_q;
`endif
              end
            end
            default: begin
              tx_data_d = tx_data_q;
              sel_d     = sel_q;
            end
          endcase
        end else begin
          tx_data_d = tx_data_q;
        end
      end

      default: begin
        busy_d     = 1'b0;
        tx_valid_d = 1'b0;
      end
    endcase

`ifdef PKT_CHECKSUM_EN
    // Sum every byte loaded after the sync byte, up to the checksum itself.
    if ((state_q == CAPTURE) && !win_active) begin
      csum_d = 8'd0;
    end else if ((state_q == SEND) && accept_s && tx_valid_d && (sel_d != CSUM)) begin
      csum_d = csum_q + tx_data_d;
    end else begin
      csum_d = csum_q;
    end
`endif
  end

  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign busy       = busy_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_waveform_packetizer.sv
module tb_waveform_packetizer;

  localparam int WINDOW_LEN = 42;
  localparam int SAMPLE_W   = 14;

  logic                clk = 1'b0;
  logic                rst;
  logic                win_active;
  logic [SAMPLE_W-1:0] win_sample;
  logic [SAMPLE_W-1:0] pulse_height;
  logic [7:0]          tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic                busy;
  logic [7:0]          drop_count;

  waveform_packetizer #(.WINDOW_LEN(WINDOW_LEN), .SAMPLE_W(SAMPLE_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .win_active   (win_active),
    .win_sample   (win_sample),
    .pulse_height (pulse_height),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         is_first;
    bit         is_last;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   seq_m = 0;
  int   drop_m = 0;
  int   t_first = 0;
  int   t_last = 0;
  int   ready_mode = 0;
  int   samp [64];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int flen(input int len);
`ifdef PKT_CHECKSUM_EN
    return pkt_pkg::HDR_BYTES + 2 * len + 1;
`else
    return pkt_pkg::HDR_BYTES + 2 * len;
`endif
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference frame for a captured window of n samples.
  task automatic push_frame(input int n, input int ph);
    int len;
    int sum;
    int b[$];
    len = (n > WINDOW_LEN) ? WINDOW_LEN : n;
    b.push_back(seq_m);
    b.push_back(len);
    b.push_back((ph >> 8) & 255);
    b.push_back(ph & 255);
    for (int i = 0; i < len; i++) begin
      b.push_back((samp[i] >> 8) & 255);
      b.push_back(samp[i] & 255);
    end
    sum = 0;
    foreach (b[i]) sum += b[i];
`ifdef PKT_CHECKSUM_EN
    b.push_back(sum % 256);
`endif
    exp_q.push_back('{b: 8'hA5, is_first: 1'b1, is_last: 1'b0});
    foreach (b[i]) exp_q.push_back('{b: 8'(b[i]), is_first: 1'b0, is_last: (i == b.size() - 1)});
    seq_m = (seq_m + 1) % 256;
  endtask

  // Drive one window of n samples; a window starting while a frame is still
  // owed is a drop.
  task automatic send_window(input int n, input int ph);
    bit captured;
    win_active   = 1'b1;
    win_sample   = SAMPLE_W'(samp[0]);
    pulse_height = SAMPLE_W'(ph);
    captured = (exp_q.size() == 0);
    if (captured) push_frame(n, ph);
    else drop_m = (drop_m >= 255) ? 255 : drop_m + 1;
    tick;
    if (captured) chk("busy_rise", busy, 1);
    for (int i = 1; i < n; i++) begin
      win_sample = SAMPLE_W'(samp[i]);
      tick;
    end
    win_active = 1'b0;
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) samp[i] = int'($urandom_range(0, (1 << SAMPLE_W) - 1));
  endtask

  // Waits until every expected byte has been transferred; returns right after
  // the edge that accepted the last byte.
  task automatic wait_idle;
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 4000) begin
      tick;
      k++;
    end
    chk("idle_timeout", int'(k < 4000), 1);
    chk("busy_fall", busy, 0);
    chk("valid_fall", tx_valid, 0);
  endtask

  // Cycle counter.
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready pattern generator.
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Scoreboard monitor: checks every transferred byte and stall stability.
  initial begin
    exp_t e;
    bit   prev_stall;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", tx_valid, 1);
          chk("stall_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: actual=%02h required=none (cycle %0d)", tx_data, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("frame_byte", tx_data, e.b);
            if (e.is_first) t_first = cyc;
            if (e.is_last)  t_last  = cyc;
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data  = tx_data;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int n;
    rst          = 1'b1;
    win_active   = 1'b0;
    win_sample   = '0;
    pulse_height = '0;
    repeat (3) tick;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_count, 0);
    rst = 1'b0;
    repeat (2) tick;

    // 10-sample window 100..109, ph=500, ready held high.
    ready_mode = 0;
    for (int i = 0; i < 10; i++) samp[i] = 100 + i;
    send_window(10, 500);
    f = cyc;
    wait_idle;
    chk("sync_latency", t_first, f + 1);
    chk("frame_span", t_last - t_first, flen(10) - 1);
    tick;

    // 60-cycle window truncated to WINDOW_LEN.
    fill_rand(60);
    send_window(60, int'($urandom_range(0, (1 << SAMPLE_W) - 1)));
    wait_idle;
    chk("trunc_span", t_last - t_first, flen(WINDOW_LEN) - 1);
    tick;

    // Same window with ready toggling every cycle.
    ready_mode = 1;
    for (int i = 0; i < 10; i++) samp[i] = 100 + i;
    send_window(10, 500);
    wait_idle;
    ready_mode = 0;
    tick;

    // Two windows during one frame, then a third after it.
    fill_rand(20);
    send_window(20, 1234);
    tick;
    fill_rand(1);
    send_window(1, 7);
    tick;
    send_window(1, 8);
    tick;
    wait_idle;
    chk("drop_two", drop_count, drop_m);
    tick;
    fill_rand(3);
    send_window(3, 99);
    wait_idle;
    tick;

    // Window rising in the very cycle the last byte is accepted.
    fill_rand(2);
    send_window(2, 321);
    repeat (flen(2)) tick;
    fill_rand(3);
    send_window(3, 55);
    tick;
    chk("coincident_busy", busy, 0);
    chk("coincident_drop", drop_count, drop_m);
    repeat (20) tick;
    chk("no_partial_capture", busy, 0);

    // Randomized frames with random ready; wraps the sequence number.
    ready_mode = 2;
    for (int it = 0; it < 258; it++) begin
      n = int'($urandom_range(1, 5));
      fill_rand(n);
      send_window(n, int'($urandom_range(0, (1 << SAMPLE_W) - 1)));
      tick;
      if ($urandom_range(0, 3) == 0) begin
        fill_rand(1);
        send_window(1, 1);
        tick;
      end
      wait_idle;
      repeat ($urandom_range(0, 2)) tick;
    end
    chk("rand_drops", drop_count, drop_m);
    ready_mode = 0;
    tick;

    // Saturation: 300 windows while a frame is stalled.
    ready_mode = 3;
    fill_rand(1);
    send_window(1, 42);
    tick;
    for (int k = 0; k < 300; k++) begin
      send_window(1, 3);
      tick;
    end
    chk("drop_saturate", drop_count, drop_m);
    chk("drop_sat_255", drop_count, 255);
    ready_mode = 0;
    wait_idle;
    tick;

    // Reset while the PH_HI byte is presented.
    fill_rand(5);
    send_window(5, 777);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    chk("abort_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_drop", drop_count, 0);
    rst = 1'b0;
    exp_q.delete();
    seq_m  = 0;
    drop_m = 0;
    repeat (2) tick;
    fill_rand(4);
    send_window(4, 600);
    wait_idle;
    chk("post_reset_drop", drop_count, 0);
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
